dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised, multi-cycle data-memory controller for the MIPS pipeline's MEM stage. It replaces the single-cycle combinational-read `dmem` with a word-addressed store that has configurable width, depth and wait states, byte-lane writes and a stall handshake. The CPU top instantiates it between the core's `aluout`/`writedata`/`memwrite` outputs and its `readdata` input. The core holds the MEM stage while `stall` is high.

## Interface
- `WIDTH`, 32: data word width in bits; a multiple of 8.
- `DEPTH`, 64: number of words; a power of two.
- `WAIT`, 2: wait states per access, 0..15.

- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: **asynchronous, active-low** reset.
- `memread`  in  1: read request.
- `memwrite`  in  1: write request.
- `be`  in  WIDTH/8: byte-lane write enables.
- `addr`  in  32: byte address.
- `wdata`  in  WIDTH: write data.
- `rdata`  out  WIDTH: registered read data.
- `stall`  out  1: holds the pipeline while an access is pending.
- `done`  out  1: one-cycle completion pulse.
- `misalign`  out  1: alignment fault; present only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- `req = memread | memwrite`.
- If both `memread` and `memwrite` are high, the access is a write. `rdata` is left unchanged.
- Word index is `addr[AW+BW-1:BW]`, where `BW = $clog2(WIDTH/8)` and `AW = $clog2(DEPTH)`.
  - Address bits above `AW+BW-1` are ignored, so addresses wrap modulo `DEPTH`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `req=1`, `WAIT>0`: load `cnt=WAIT-1` and go to BUSY.
  - IDLE, `req=1`, `WAIT==0`: perform the access and go to DONE.
  - BUSY, `cnt!=0`: decrement `cnt`.
  - BUSY, `cnt==0`: perform the access and go to DONE.
  - BUSY, `req` drops (flush): abort. Go to IDLE, write nothing, leave `rdata` unchanged.
  - DONE, `req=1`: treat as a new request; same transitions as IDLE.
  - DONE, `req=0`: go to IDLE.
- Performing an access:
  - Write: commit the lanes where `be[i]=1`. Other lanes keep their old contents.
  - Read: register the full word into `rdata`.
- Outputs:
  - `stall = req & (state != DONE)`. This is combinational.
  - `done = (state == DONE)`.
- The core must hold `memread`, `memwrite`, `addr`, `be` and `wdata` stable while `stall=1`. Changes to these inputs during BUSY are undefined, except `req` dropping (abort).
- Storage is not reset. Contents after power-up are undefined.
- Reset, including mid-access:
  - State goes to IDLE and `cnt` to 0.
  - `rdata`, `done` and `misalign` go to 0.
  - An in-flight write is discarded.

## Timing
- A request seen in IDLE at cycle 0 has its access performed at the edge ending cycle `WAIT`.
  - `done=1` and read data are valid in cycle `WAIT+1`.
  - `stall` is high during cycles 0..`WAIT`.
- `WAIT=0`: single-cycle access. `stall` is high for one cycle.
- Back-to-back requests: DONE→BUSY happens without passing through IDLE. Sustained throughput is one access per `WAIT+1` cycles.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`.
- Defined:
  - An access with `addr[BW-1:0] != 0` is a fault. It completes with normal timing but performs no write and does not update `rdata`.
  - `misalign` is 1 during the fault's DONE cycle; otherwise 0.
- Undefined:
  - The `misalign` port is absent.
  - Low address bits are ignored; the access goes to the containing word.

## Structure
- Package `mem_pkg` holds:
  - the `dmem_state_t` enum {IDLE, BUSY, DONE};
  - default parameter constants;
  - the `BW`/`AW` width helper functions.
- Sub-module `dmem_array`: a synchronous storage array with per-lane write enable and registered read, parametrised by `WIDTH` and `DEPTH`.
- `dmem_ctrl` contains the FSM, the wait counter, the stall/done logic and the optional trap logic.

## Test plan
- **Write then read**, `WAIT=2`: write `0xDEADBEEF` to `0x10` with `be=4'hF`, then read `0x10`.
  - Each access: `stall` high for 3 cycles, then `done` for 1 cycle.
  - Read returns `rdata=0xDEADBEEF`.
- **Byte lanes**: after the above, write `0x000000AA` to `0x10` with `be=4'h1`, then read `0x10` → `0xDEADBEAA`.
- **Abort**: start a write of `0x12345678` to `0x20`. Drop `memwrite` in the first BUSY cycle.
  - FSM returns to IDLE with no `done`.
  - A later read of `0x20` returns its prior value.
- **Wrap and back-to-back**, `DEPTH=64`, `WAIT=0`: write `0x5` to `0x100`, read `0x0` in the next cycle.
  - Read returns `0x5`.
  - `done` is high in two consecutive cycles.
- **Reset mid-access**: assert `reset=0` during BUSY of a write of `0xFFFFFFFF` to `0x8`.
  - `rdata`, `done` and `stall` are 0 immediately.
  - A later read of `0x8` returns the old value.
- **Misalign trap** (macro defined): write to `0x13`.
  - `misalign=1` with `done`.
  - Word `0x10` is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Optional feature macro used by dmem_ctrl: DMEM_MISALIGN_TRAP_EN.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 64;
   localparam int DEF_WAIT  = 2;

   // Wait counter holds 0..15.
   localparam int CNT_W = 4;

   // Byte-offset bits inside one word.
   function automatic int bw_of(input int width);
      return $clog2(width / 8);
   endfunction

   // Word-index bits for the array.
   function automatic int aw_of(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enable and a registered
// read port. Storage itself is never reset; only the read register is.
module dmem_array
   import mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic                       re,
   input  logic [WIDTH/8-1:0]         be,
   input  logic [aw_of(DEPTH)-1:0]    idx,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_d;
   logic [WIDTH-1:0] rdata_q;

   // Commit only the enabled byte lanes; other lanes keep their contents.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read register holds its value between reads.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[idx];
   end

   // Read register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage: IDLE/BUSY/DONE FSM,
// wait-state counter, stall/done handshake and byte-lane writes.
// Optional alignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
//
// Handshake: the core raises memread/memwrite (req) and holds req, addr, be
// and wdata stable while stall=1. stall falls in the cycle done pulses; that
// cycle the core may present the next request (accepted without IDLE) or drop
// req. Dropping req while BUSY aborts the access with no side effects.
module dmem_ctrl
   import mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int WAIT  = DEF_WAIT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memread,
   input  logic               memwrite,
   input  logic [WIDTH/8-1:0] be,
   input  logic [31:0]        addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata,
   output logic               stall,
   output logic               done,
`ifdef DMEM_MISALIGN_TRAP_EN
   output logic               misalign,
`endif
   output logic [1:0]         dbg_state
);

   localparam int               BW       = bw_of(WIDTH);
   localparam int               AW       = aw_of(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_M1  = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;
   localparam logic [31:0]      LOW_MASK = 32'(WIDTH / 8 - 1);

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req;
   logic             access;
   logic             fault;
   logic             we;
   logic             re;
   logic [AW-1:0]    word_idx;
   logic             unused_addr;

   assign req         = memread | memwrite;
   assign word_idx    = addr[AW+BW-1:BW];
   assign unused_addr = ^addr;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   assign fault = |(addr & LOW_MASK);
`else
   assign fault = 1'b0;
`endif

   // Next-state, wait counter and the cycle in which the access is performed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (req) begin
               if (WAIT == 0) begin
                  access  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = WAIT_M1;
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   // Fault flag is high exactly in the DONE cycle of a faulting access.
   always_comb begin
      misalign_d = access & fault;
   end
`endif

   // FSM state, counter and registered fault flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // A write wins over a simultaneous read; reset suppresses any commit.
   assign we = access & memwrite & ~fault & reset;
   assign re = access & memread & ~memwrite & ~fault & reset;

   dmem_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst_n (reset),
      .we    (we),
      .re    (re),
      .be    (be),
      .idx   (word_idx),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign stall     = req & reset & (state_q != DONE);
   assign done      = (state_q == DONE);
   assign dbg_state = state_q;
`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign  = misalign_q;
`endif

endmodule
